// File: rtl/nn_infer_scheduler.sv
// nn_infer_scheduler
//
// Shares a single MNIST classifier core among N_REQ requesters. Requests are
// picked round-robin, one inference is outstanding at a time, and the label
// that comes back is routed only to the requester that issued the image. A
// timer aborts the inference when the core does not answer within
// TIMEOUT_CYCLES cycles, and the owner then receives the all-ones label.
//
// Ports
//   clk_i         rising-edge clock
//   reset_i       asynchronous, active-high reset
//   req_valid_i   per-requester image valid
//   req_data_i    images; requester k occupies bits [k*IMG_W +: IMG_W]
//   req_ready_o   one-hot accept strobe (same cycle as the grant)
//   rsp_valid_o   one-hot label valid, asserted to the owner only
//   rsp_data_o    label bus shared by all requesters, holds its last value
//   rsp_ready_i   per-requester label accept
//   core_valid_o  image valid to the core
//   core_data_o   image to the core
//   core_ready_i  core accepts the image
//   core_valid_i  core label valid
//   core_data_i   core label
//   core_ready_o  scheduler accepts a label (only while waiting for one)
//   busy_o        high whenever a transaction is in flight
//   timeout_o     one-cycle pulse when a transaction is aborted by the timer
module nn_infer_scheduler #(
  parameter int N_REQ          = 4,
  parameter int IMG_W          = 784,
  parameter int LBL_W          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  input  logic [N_REQ*IMG_W-1:0] req_data_i,
  output logic [N_REQ-1:0]       req_ready_o,
  output logic [N_REQ-1:0]       rsp_valid_o,
  output logic [LBL_W-1:0]       rsp_data_o,
  input  logic [N_REQ-1:0]       rsp_ready_i,
  output logic                   core_valid_o,
  output logic [IMG_W-1:0]       core_data_o,
  input  logic                   core_ready_i,
  input  logic                   core_valid_i,
  input  logic [LBL_W-1:0]       core_data_i,
  output logic                   core_ready_o,
  output logic                   busy_o,
  output logic                   timeout_o
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // The timer only has to reach TIMEOUT_CYCLES-1.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    rr_q, rr_d;
  logic [PW-1:0]    grant_q, grant_d;
  logic [IMG_W-1:0] img_q, img_d;
  logic [LBL_W-1:0] rsp_q, rsp_d;
  logic [TW-1:0]    timer_q, timer_d;

  logic             gnt_found;
  logic [PW-1:0]    gnt_idx;
  logic             tmo_hit;

  // Round-robin search starting at rr_q. The candidate index is formed one bit
  // wider than the pointer so the modulo wrap works for non-power-of-two N_REQ.
  always_comb begin
    logic [PW:0] cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_q} + (PW+1)'(i);
      if (cand >= (PW+1)'(N_REQ)) begin
        cand = cand - (PW+1)'(N_REQ);
      end
      if (!gnt_found && req_valid_i[cand[PW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[PW-1:0];
      end
    end
  end

  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (timer_q == T_LAST);

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    grant_d      = grant_q;
    img_d        = img_q;
    rsp_d        = rsp_q;
    timer_d      = timer_q;
    req_ready_o  = '0;
    rsp_valid_o  = '0;
    core_valid_o = 1'b0;
    core_ready_o = 1'b0;
    timeout_o    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // The ready strobe is combinational, so it is masked while reset is
        // held to keep every output low during reset.
        if (gnt_found && !reset_i) begin
          req_ready_o = N_REQ'(1) << gnt_idx;
          img_d       = req_data_i[gnt_idx*IMG_W +: IMG_W];
          grant_d     = gnt_idx;
          rr_d        = (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          state_d     = S_ISSUE;
        end
      end

      S_ISSUE: begin
        core_valid_o = 1'b1;
        if (core_ready_i) begin
          timer_d = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        core_ready_o = 1'b1;
        // A label arriving in the expiry cycle still wins over the abort.
        if (core_valid_i) begin
          rsp_d   = core_data_i;
          state_d = S_RESP;
        end else if (tmo_hit) begin
          rsp_d     = '1;
          timeout_o = 1'b1;
          state_d   = S_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_RESP: begin
        rsp_valid_o = N_REQ'(1) << grant_q;
        if (rsp_ready_i[grant_q]) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      img_q   <= '0;
      rsp_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      img_q   <= img_d;
      rsp_q   <= rsp_d;
      timer_q <= timer_d;
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign core_data_o = img_q;
  assign rsp_data_o  = rsp_q;

endmodule

// File: tb/tb_nn_infer_scheduler.sv
// Bench for nn_infer_scheduler: N_REQ=4, 784-bit images, 4-bit labels,
// 16-cycle timeout. Inputs change 1 ns after the rising edge; a reference
// model is compared with the DUT on every falling edge, and directed scenarios
// check hand-derived values at 3 ns after the rising edge.
module tb_nn_infer_scheduler;

  localparam int N  = 4;
  localparam int IW = 784;
  localparam int LW = 4;
  localparam int TO = 16;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic [N-1:0]    req_valid_i;
  logic [N*IW-1:0] req_data_i;
  logic [N-1:0]    req_ready_o;
  logic [N-1:0]    rsp_valid_o;
  logic [LW-1:0]   rsp_data_o;
  logic [N-1:0]    rsp_ready_i;
  logic            core_valid_o;
  logic [IW-1:0]   core_data_o;
  logic            core_ready_i = 1'b0;
  logic            core_valid_i = 1'b0;
  logic [LW-1:0]   core_data_i  = '0;
  logic            core_ready_o;
  logic            busy_o;
  logic            timeout_o;

  nn_infer_scheduler #(
    .N_REQ(N), .IMG_W(IW), .LBL_W(LW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_ready_i(rsp_ready_i),
    .core_valid_o(core_valid_o), .core_data_o(core_data_o), .core_ready_i(core_ready_i),
    .core_valid_i(core_valid_i), .core_data_i(core_data_i), .core_ready_o(core_ready_o),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- core stand-in ----------------
  // auto mode: always ready, label one cycle after the image is accepted.
  logic          auto_en = 1'b0;
  logic          lbl_from_img = 1'b0;
  logic [LW-1:0] auto_lbl = '0;
  logic          man_core_ready = 1'b0;
  logic          man_core_valid = 1'b0;
  logic [LW-1:0] man_core_data = '0;
  logic          acc_seen = 1'b0;

  always @(negedge clk_i) acc_seen = core_valid_o && core_ready_i && !reset_i;

  initial begin
    forever begin
      @(posedge clk_i);
      #2;
      core_ready_i = auto_en ? 1'b1 : man_core_ready;
      core_valid_i = auto_en ? acc_seen : man_core_valid;
      core_data_i  = auto_en ? (lbl_from_img ? core_data_o[LW-1:0] : auto_lbl) : man_core_data;
    end
  end

  // ---------------- reference model ----------------
  // One transaction at a time: an owner, whether the image has been handed
  // to the core, whether a label is held, and how long we have waited.
  bit            m_busy, m_issued, m_have;
  int            m_owner, m_rr, m_wcnt;
  logic [IW-1:0] m_img;
  logic [LW-1:0] m_rsp;

  int grant_log[$];
  int rsp_own[$];
  int rsp_lbl[$];
  int tmo_cnt = 0;

  always @(negedge clk_i) begin : cmp
    int            g, c;
    logic [N-1:0]  tmp, e_rdy, e_rv;
    logic          e_cv, e_cr, e_to;
    if (reset_i) begin
      chk("rst_req_ready", req_ready_o, '0);
      chk("rst_rsp_valid", rsp_valid_o, '0);
      chk("rst_rsp_data", rsp_data_o, '0);
      chk("rst_core_valid", core_valid_o, '0);
      chk("rst_core_data", core_data_o, '0);
      chk("rst_core_ready", core_ready_o, '0);
      chk("rst_busy", busy_o, '0);
      chk("rst_timeout", timeout_o, '0);
      m_busy = 0; m_issued = 0; m_have = 0;
      m_owner = 0; m_rr = 0; m_wcnt = 0;
      m_img = '0; m_rsp = '0;
    end else begin
      g = -1;
      if (!m_busy) begin
        for (int j = 0; j < N; j++) begin
          c = (m_rr + j) % N;
          tmp = req_valid_i >> c;
          if (g < 0 && tmp[0]) g = c;
        end
      end
      e_rdy = (g >= 0) ? (N'(1) << g) : '0;
      e_cv  = m_busy && !m_issued;
      e_cr  = m_busy && m_issued && !m_have;
      e_to  = e_cr && (TO != 0) && (m_wcnt == TO - 1) && !core_valid_i;
      e_rv  = m_have ? (N'(1) << m_owner) : '0;

      chk("mdl_req_ready", req_ready_o, e_rdy);
      chk("mdl_core_valid", core_valid_o, e_cv);
      chk("mdl_core_data", core_data_o, m_img);
      chk("mdl_core_ready", core_ready_o, e_cr);
      chk("mdl_timeout", timeout_o, e_to);
      chk("mdl_rsp_valid", rsp_valid_o, e_rv);
      chk("mdl_rsp_data", rsp_data_o, m_rsp);
      chk("mdl_busy", busy_o, m_busy);

      // Logs of what the DUT itself did, for the directed checks.
      for (int j = 0; j < N; j++) begin
        tmp = req_ready_o >> j;
        if (tmp[0]) grant_log.push_back(j);
        tmp = (rsp_valid_o & rsp_ready_i) >> j;
        if (tmp[0]) begin
          rsp_own.push_back(j);
          rsp_lbl.push_back(int'(rsp_data_o));
        end
      end
      if (timeout_o) tmo_cnt++;

      // Advance the model to the state after the coming rising edge.
      if (g >= 0) begin
        m_busy = 1; m_issued = 0; m_have = 0;
        m_owner = g;
        m_img = IW'(req_data_i >> (g * IW));
        m_rr = (g + 1) % N;
      end else if (m_busy && !m_issued) begin
        if (core_ready_i) begin
          m_issued = 1;
          m_wcnt = 0;
        end
      end else if (m_busy && !m_have) begin
        if (core_valid_i) begin
          m_rsp = core_data_i;
          m_have = 1;
        end else if (e_to) begin
          m_rsp = '1;
          m_have = 1;
        end else begin
          m_wcnt++;
        end
      end else if (m_have) begin
        tmp = rsp_ready_i >> m_owner;
        if (tmp[0]) begin
          m_busy = 0; m_issued = 0; m_have = 0;
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  bit           auto_drop = 0;
  logic [N-1:0] last_rdy = '0;

  task automatic settle();
    #2;
    last_rdy = req_ready_o;
  endtask

  task automatic adv();
    @(posedge clk_i);
    #1;
    if (auto_drop) req_valid_i = req_valid_i & ~last_rdy;
  endtask

  task automatic tick();
    settle();
    adv();
  endtask

  task automatic clear_logs();
    grant_log.delete();
    rsp_own.delete();
    rsp_lbl.delete();
    tmo_cnt = 0;
  endtask

  task automatic drain(input string nm);
    bit done;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      settle();
      if (!busy_o && req_valid_i == '0) done = 1;
      adv();
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_drain: busy_o=%0b after 60 cycles, expected idle", nm, busy_o);
    end
  endtask

  task automatic chk_rsp(input string nm, input int idx, input int own, input int lbl);
    chk({nm, "_owner"}, IW'(rsp_own.size() > idx ? rsp_own[idx] : -1), IW'(own));
    chk({nm, "_label"}, IW'(rsp_lbl.size() > idx ? rsp_lbl[idx] : -1), IW'(lbl));
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin : stim
    logic [IW-1:0] pat;
    int            exp_g[5];
    int            guard;
    pat = {98{8'hA5}};
    exp_g = '{0, 1, 2, 3, 0};

    reset_i = 1'b1;
    req_valid_i = '1;
    req_data_i = '0;
    rsp_ready_i = '0;
    @(posedge clk_i);
    #1;
    // Valid requests during reset must not be acknowledged.
    settle();
    chk("reset_req_ready", req_ready_o, '0);
    chk("reset_busy", busy_o, '0);
    chk("reset_core_valid", core_valid_o, '0);
    adv();
    req_valid_i = '0;
    tick();
    reset_i = 1'b0;
    tick();

    // All four requesting continuously: grants 0,1,2,3,0, label k+1 to owner k.
    clear_logs();
    for (int k = 0; k < N; k++) req_data_i[k*IW +: IW] = IW'(k + 1);
    lbl_from_img = 1'b1;
    auto_en = 1'b1;
    rsp_ready_i = '1;
    req_valid_i = '1;
    guard = 0;
    while (grant_log.size() < 5 && guard < 40) begin
      tick();
      guard++;
    end
    req_valid_i = '0;
    drain("rr");
    chk("rr_grant_count", IW'(grant_log.size()), IW'(5));
    for (int i = 0; i < 5; i++) begin
      chk("rr_grant_order", IW'(grant_log.size() > i ? grant_log[i] : -1), IW'(exp_g[i]));
    end
    chk("rr_rsp_count", IW'(rsp_own.size()), IW'(5));
    for (int i = 0; i < 5; i++) chk_rsp("rr_rsp", i, exp_g[i], exp_g[i] + 1);

    // Core stalls its ready for 5 cycles while another requester waits.
    clear_logs();
    lbl_from_img = 1'b0;
    auto_en = 1'b0;
    man_core_ready = 1'b0;
    auto_drop = 1;
    req_data_i = '0;
    req_data_i[1*IW +: IW] = pat;
    req_valid_i = 4'b0010;
    settle();
    chk("stall_grant", req_ready_o, 4'b0010);
    adv();
    req_valid_i[3] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("stall_core_valid", core_valid_o, 1'b1);
      chk("stall_core_data", core_data_o, pat);
      chk("stall_no_grant", req_ready_o, '0);
      adv();
    end
    auto_en = 1'b1;
    auto_lbl = 4'd7;
    drain("stall");
    chk_rsp("stall_rsp0", 0, 1, 7);
    chk_rsp("stall_rsp1", 1, 3, 7);

    // Single request from requester 2, all-ones image, core answers 8.
    clear_logs();
    req_data_i = '0;
    req_data_i[2*IW +: IW] = '1;
    auto_lbl = 4'd8;
    req_valid_i = 4'b0100;
    settle();
    chk("single_c0_ready", req_ready_o, 4'b0100);
    adv();
    settle();
    chk("single_c1_core_valid", core_valid_o, 1'b1);
    chk("single_c1_core_data", core_data_o, '1);
    adv();
    settle();
    chk("single_c2_core_ready", core_ready_o, 1'b1);
    chk("single_c2_rsp_valid", rsp_valid_o, '0);
    adv();
    settle();
    chk("single_c3_rsp_valid", rsp_valid_o, 4'b0100);
    chk("single_c3_rsp_data", rsp_data_o, 4'd8);
    adv();
    settle();
    chk("single_c4_busy", busy_o, 1'b0);
    adv();

    // Owner (2) holds off its rsp_ready for 10 cycles; others' ready ignored.
    clear_logs();
    auto_lbl = 4'd6;
    rsp_ready_i = 4'b1011;
    req_valid_i = 4'b0100;
    settle();
    chk("hold_grant", req_ready_o, 4'b0100);
    adv();
    req_valid_i[1] = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("hold_rsp_valid", rsp_valid_o, 4'b0100);
      chk("hold_rsp_data", rsp_data_o, 4'd6);
      chk("hold_no_grant", req_ready_o, '0);
      adv();
    end
    rsp_ready_i = 4'b0100;
    settle();
    chk("hold_release_rsp_valid", rsp_valid_o, 4'b0100);
    adv();
    settle();
    chk("hold_next_grant", req_ready_o, 4'b0010);
    adv();
    rsp_ready_i = '1;
    drain("hold");

    // Core never answers: abort after 16 cycles in WAIT, label 4'hF.
    clear_logs();
    auto_en = 1'b0;
    man_core_ready = 1'b1;
    man_core_valid = 1'b0;
    rsp_ready_i = '0;
    req_valid_i = 4'b0001;
    settle();
    chk("tmo_grant", req_ready_o, 4'b0001);
    adv();
    settle();
    chk("tmo_issue", core_valid_o, 1'b1);
    adv();
    for (int i = 0; i < 15; i++) begin
      settle();
      chk("tmo_early_pulse", timeout_o, 1'b0);
      chk("tmo_wait_ready", core_ready_o, 1'b1);
      adv();
    end
    settle();
    chk("tmo_pulse", timeout_o, 1'b1);
    chk("tmo_pulse_rsp_valid", rsp_valid_o, '0);
    adv();
    settle();
    chk("tmo_rsp_valid", rsp_valid_o, 4'b0001);
    chk("tmo_rsp_data", rsp_data_o, 4'hF);
    chk("tmo_pulse_off", timeout_o, 1'b0);
    adv();
    settle();
    chk("tmo_rsp_hold", rsp_valid_o, 4'b0001);
    adv();
    rsp_ready_i = 4'b0001;
    tick();
    settle();
    chk("tmo_idle", busy_o, 1'b0);
    chk("tmo_rsp_data_kept", rsp_data_o, 4'hF);
    adv();
    chk("tmo_pulse_count", IW'(tmo_cnt), IW'(1));
    rsp_ready_i = '1;

    // Reset in WAIT: everything clears, pointer returns to 0, stale label dropped.
    clear_logs();
    req_valid_i = 4'b0010;
    settle();
    chk("rstw_grant", req_ready_o, 4'b0010);
    adv();
    tick();
    settle();
    chk("rstw_in_wait", core_ready_o, 1'b1);
    adv();
    reset_i = 1'b1;
    settle();
    chk("rstw_busy", busy_o, 1'b0);
    chk("rstw_core_ready", core_ready_o, 1'b0);
    chk("rstw_core_data", core_data_o, '0);
    chk("rstw_rsp_valid", rsp_valid_o, '0);
    adv();
    tick();
    reset_i = 1'b0;
    man_core_valid = 1'b1;
    man_core_data = 4'd9;
    tick();
    settle();
    chk("rstw_stale_core_ready", core_ready_o, 1'b0);
    chk("rstw_stale_rsp_data", rsp_data_o, 4'd0);
    adv();
    man_core_valid = 1'b0;
    auto_en = 1'b1;
    auto_lbl = 4'd3;
    req_data_i = '0;
    req_data_i[0*IW +: IW] = IW'(32'h1234_5678);
    req_valid_i = 4'b0101;
    settle();
    chk("rstw_regrant_0", req_ready_o, 4'b0001);
    adv();
    drain("rstw");
    chk("rstw_rsp_count", IW'(rsp_own.size()), IW'(2));
    chk_rsp("rstw_rsp0", 0, 0, 3);
    chk_rsp("rstw_rsp1", 1, 2, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
